// File: rtl/a2d_scan_intf_if.sv
// SPI bus between the A2D scanner (master) and the DE0-Nano A2D converter (slave).
interface a2d_scan_intf_if;
   logic MISO;
   logic SS_n;
   logic SCLK;
   logic MOSI;

   modport master (input MISO, output SS_n, output SCLK, output MOSI);
   modport slave  (output MISO, input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/a2d_scan_intf.sv
// Multi-channel A2D scanner: pipelined channel selects over an embedded 16-bit SPI master,
// optional averaging over 2^AVG_LOG2 passes, and a registered per-channel result bank.
module a2d_scan_intf #(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned RES_W    = 12,
   parameter int unsigned AVG_LOG2 = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   a2d_scan_intf_if.master   spi,
   input  logic              strt_scan,
   input  logic              cont,
   input  logic [2:0]        rd_ch,
   output logic [RES_W-1:0]  rd_res,
   output logic              busy,
   output logic              scan_cmplt,
   output logic [NUM_CH-1:0] res_vld
);
   localparam int unsigned     ACC_W    = RES_W + AVG_LOG2;
   localparam int unsigned     NUM_XFER = NUM_CH * (1 << AVG_LOG2) + 1;
   localparam int unsigned     IDX_W    = $clog2(NUM_XFER);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_XFER - 1);
   localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);
   localparam logic [4:0]       DIV_IDLE = 5'b10111;

   typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

   // SPI master state
   logic [4:0]  sclk_div_q;
   logic [15:0] shft_q;
   logic [3:0]  bit_cnt_q;
   logic        ss_n_q;
   logic        miso_smpl_q;
   logic        first_fall_q;
   logic        done_q;
   logic        sclk_rise;
   logic        sclk_fall;

   // Scanner state
   state_e           state_q, state_d;
   logic [IDX_W-1:0] xfer_idx_q, xfer_idx_d;
   logic [2:0]       cmd_ch_q, cmd_ch_d;
   logic [2:0]       acc_ch_q, acc_ch_d;
   logic             restart_q, restart_d;
   logic [2:0]       next_ch;
   logic             snd;
   logic [2:0]       snd_ch;
   logic             start;
   logic             acc_en;
   logic             commit;
   logic [RES_W-1:0] resp;

   logic [ACC_W-1:0] acc_q   [NUM_CH];
   logic [ACC_W-1:0] acc_nxt [NUM_CH];
   logic [RES_W-1:0] bank_q  [NUM_CH];
   logic             scan_cmplt_q;
   logic [NUM_CH-1:0] res_vld_q;

   //---------------------------------------------------------------------------------------------
   // SPI master: SCLK = clk/32, idles high; MOSI changes on SCLK fall, MISO sampled on SCLK rise.
   // The first fall after SS_n drops only starts the clock; the 16th shift happens without a fall
   // so SCLK returns high at the end of the frame.
   //---------------------------------------------------------------------------------------------
   assign sclk_rise = (sclk_div_q == 5'b01111);
   assign sclk_fall = (sclk_div_q == 5'b11111);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_div_q   <= DIV_IDLE;
         shft_q       <= '0;
         bit_cnt_q    <= '0;
         ss_n_q       <= 1'b1;
         miso_smpl_q  <= 1'b0;
         first_fall_q <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (snd) begin
            ss_n_q       <= 1'b0;
            sclk_div_q   <= DIV_IDLE;
            shft_q       <= {2'b00, snd_ch, 11'h000};
            bit_cnt_q    <= '0;
            first_fall_q <= 1'b1;
         end else if (!ss_n_q) begin
            if (sclk_rise) begin
               miso_smpl_q <= spi.MISO;
            end
            if (sclk_fall) begin
               if (first_fall_q) begin
                  first_fall_q <= 1'b0;
                  sclk_div_q   <= sclk_div_q + 5'd1;
               end else begin
                  shft_q    <= {shft_q[14:0], miso_smpl_q};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     ss_n_q     <= 1'b1;
                     done_q     <= 1'b1;
                     sclk_div_q <= DIV_IDLE;
                  end else begin
                     sclk_div_q <= sclk_div_q + 5'd1;
                  end
               end
            end else begin
               sclk_div_q <= sclk_div_q + 5'd1;
            end
         end
      end
   end

   assign spi.SS_n = ss_n_q;
   assign spi.SCLK = sclk_div_q[4];
   assign spi.MOSI = shft_q[15];
   assign resp     = shft_q[RES_W-1:0];

   //---------------------------------------------------------------------------------------------
   // Scan sequencer
   //---------------------------------------------------------------------------------------------
   assign next_ch = (cmd_ch_q == LAST_CH) ? 3'd0 : cmd_ch_q + 3'd1;

   always_comb begin
      state_d    = state_q;
      xfer_idx_d = xfer_idx_q;
      cmd_ch_d   = cmd_ch_q;
      acc_ch_d   = acc_ch_q;
      restart_d  = restart_q;
      snd        = 1'b0;
      snd_ch     = 3'd0;
      start      = 1'b0;
      acc_en     = 1'b0;
      commit     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (strt_scan) begin
               snd        = 1'b1;
               start      = 1'b1;
               xfer_idx_d = '0;
               cmd_ch_d   = 3'd0;
               restart_d  = 1'b0;
               state_d    = StXfer;
            end
         end
         StXfer: begin
            if (done_q) begin
               // Transaction 0 returns a stale conversion from before this scan.
               acc_en = (xfer_idx_q != '0);
               if (xfer_idx_q == LAST_IDX) begin
                  commit = 1'b1;
                  if (cont) begin
                     restart_d = 1'b1;
                     state_d   = StGap;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            snd       = 1'b1;
            restart_d = 1'b0;
            state_d   = StXfer;
            if (restart_q) begin
               xfer_idx_d = '0;
               cmd_ch_d   = 3'd0;
            end else begin
               snd_ch     = next_ch;
               xfer_idx_d = xfer_idx_q + 1'b1;
               cmd_ch_d   = next_ch;
               acc_ch_d   = cmd_ch_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         xfer_idx_q <= '0;
         cmd_ch_q   <= 3'd0;
         acc_ch_q   <= 3'd0;
         restart_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         xfer_idx_q <= xfer_idx_d;
         cmd_ch_q   <= cmd_ch_d;
         acc_ch_q   <= acc_ch_d;
         restart_q  <= restart_d;
      end
   end

   //---------------------------------------------------------------------------------------------
   // Accumulators and result bank; the commit folds in the final response via acc_nxt.
   //---------------------------------------------------------------------------------------------
   always_comb begin
      for (int n = 0; n < NUM_CH; n++) begin
         acc_nxt[n] = acc_q[n];
         if (acc_en && (acc_ch_q == 3'(n))) begin
            acc_nxt[n] = acc_q[n] + ACC_W'(resp);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NUM_CH; n++) begin
            acc_q[n]  <= '0;
            bank_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (start || commit) begin
               acc_q[n] <= '0;
            end else begin
               acc_q[n] <= acc_nxt[n];
            end
            if (commit) begin
               bank_q[n] <= RES_W'(acc_nxt[n] >> AVG_LOG2);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cmplt_q <= 1'b0;
         res_vld_q    <= '0;
      end else begin
         if (start) begin
            scan_cmplt_q <= 1'b0;
         end else if (commit) begin
            scan_cmplt_q <= 1'b1;
         end
         if (commit) begin
            res_vld_q <= {NUM_CH{1'b1}};
         end
      end
   end

   always_comb begin
      rd_res = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (rd_ch == 3'(n)) begin
            rd_res = bank_q[n];
         end
      end
   end

   assign busy       = (state_q != StIdle);
   assign scan_cmplt = scan_cmplt_q;
   assign res_vld    = res_vld_q;

endmodule
